// File: rtl/paddle_input_controller.sv
// Paddle input controller: synchronises and debounces four player buttons and
// steps/clamps two paddle positions. Define PADDLE_AI_EN to make p2 track ball_y.
module paddle_input_controller #(
   parameter int DEB_CYCLES  = 500000,
   parameter int STEP_CYCLES = 250000,
   parameter int STEP_PX     = 4,
   parameter int Y_TOP       = 16,
   parameter int Y_BOTTOM    = 464,
   parameter int BAT_SMALL   = 48,
   parameter int BAT_LARGE   = 96,
   parameter int Y_INIT      = 216,
   parameter int AI_DEADBAND = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        center,
   input  logic        bat_size,
   input  logic        p1_up,
   input  logic        p1_dn,
   input  logic        p2_up,
   input  logic        p2_dn,
   input  logic [10:0] ball_y,
   output logic [10:0] p1_y,
   output logic [10:0] p2_y
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int SW = $clog2(STEP_CYCLES + 1);

   typedef logic signed [11:0] pos_t;

   localparam pos_t LIM_SMALL  = pos_t'(Y_BOTTOM - BAT_SMALL);
   localparam pos_t LIM_LARGE  = pos_t'(Y_BOTTOM - BAT_LARGE);
   localparam pos_t HALF_SMALL = pos_t'(BAT_SMALL / 2);
   localparam pos_t HALF_LARGE = pos_t'(BAT_LARGE / 2);
   localparam pos_t TOP        = pos_t'(Y_TOP);
   localparam pos_t INIT       = pos_t'(Y_INIT);
   localparam pos_t STEP       = pos_t'(STEP_PX);

   logic [3:0]    raw_btn;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    stable;
   logic [DW-1:0] deb_cnt [4];
   logic [SW-1:0] step_cnt;
   logic          tick;
   pos_t          lim;
   pos_t          half;
   pos_t          y1;
   pos_t          y2;
   pos_t          y1_next;
   pos_t          y2_next;
   logic          p2_mv_up;
   logic          p2_mv_dn;

   assign raw_btn = {p2_dn, p2_up, p1_dn, p1_up};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_btn;
         sync2 <= sync1;
      end
   end

   // A new level is accepted only after DEB_CYCLES consecutive mismatching samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign tick = (step_cnt == SW'(STEP_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) step_cnt <= '0;
      else      step_cnt <= tick ? '0 : step_cnt + 1'b1;
   end

   assign lim  = bat_size ? LIM_LARGE  : LIM_SMALL;
   assign half = bat_size ? HALF_LARGE : HALF_SMALL;
   assign y1   = $signed({1'b0, p1_y});
   assign y2   = $signed({1'b0, p2_y});

`ifdef PADDLE_AI_EN
   pos_t ai_c;
   pos_t ai_ball;
   logic unused_p2_btn;
   assign ai_c          = y2 + half;
   assign ai_ball       = $signed({1'b0, ball_y});
   assign p2_mv_up      = (ai_ball + pos_t'(AI_DEADBAND)) < ai_c;
   assign p2_mv_dn      = ai_ball > (ai_c + pos_t'(AI_DEADBAND));
   assign unused_p2_btn = ^stable[3:2];
`else
   logic unused_ball;
   logic unused_half;
   assign p2_mv_up    = stable[2];
   assign p2_mv_dn    = stable[3];
   assign unused_ball = ^ball_y;
   assign unused_half = ^half;
`endif

   // Priority: recentre, clamp after bat growth, then a saturating step on tick.
   function automatic pos_t next_y(input pos_t y, input logic up, input logic dn,
                                   input pos_t l, input logic ctr, input logic mv);
      pos_t r;
      r = y;
      if (ctr)                   r = (INIT > l) ? l : INIT;
      else if (y > l)            r = l;
      else if (mv && up && !dn)  r = ((y - STEP) < TOP) ? TOP : (y - STEP);
      else if (mv && dn && !up)  r = ((y + STEP) > l) ? l : (y + STEP);
      return r;
   endfunction

   always_comb begin
      y1_next = next_y(y1, stable[0], stable[1], lim, center, en && tick);
      y2_next = next_y(y2, p2_mv_up, p2_mv_dn, lim, center, en && tick);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1_y <= 11'(Y_INIT);
         p2_y <= 11'(Y_INIT);
      end else begin
         p1_y <= y1_next[10:0];
         p2_y <= y2_next[10:0];
      end
   end

endmodule

// File: tb/tb_paddle_input_controller.sv
// Self-checking bench for paddle_input_controller: directed scenarios plus random
// button traffic, compared every cycle against a rule-level reference model.
module tb_paddle_input_controller;

   localparam int DEB  = 4;
   localparam int STEP = 8;
   localparam int PX   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        center = 1'b0;
   logic        bat_size = 1'b0;
   logic [3:0]  btn = 4'b0;
   logic [10:0] ball_y = 11'd0;
   logic [10:0] p1_y;
   logic [10:0] p2_y;

   int errors = 0;
   int checks = 0;
   bit model_on = 0;

   paddle_input_controller #(
      .DEB_CYCLES(DEB), .STEP_CYCLES(STEP), .STEP_PX(PX)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .center(center), .bat_size(bat_size),
      .p1_up(btn[0]), .p1_dn(btn[1]), .p2_up(btn[2]), .p2_dn(btn[3]),
      .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] b, input logic e, input logic bs, input int n);
      btn = b;
      en = e;
      bat_size = bs;
      repeat (n) @(negedge clk);
   endtask

   // Reference model: raw-sample history per button, edge count since reset for the tick.
   int raw_hist [4][DEB+1];
   bit stab [4];
   int edges = 0;
   int m_y [2] = '{216, 216};

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            stab[i] = 0;
            for (int j = 0; j <= DEB; j++) raw_hist[i][j] = 0;
         end
         edges = 0;
         m_y[0] = 216;
         m_y[1] = 216;
      end else begin
         int h, lim, c, nmis;
         bit tk, up, dn;
         h = bat_size ? 96 : 48;
         lim = 464 - h;
         tk = (edges % STEP) == (STEP - 1);
         edges++;
         for (int p = 0; p < 2; p++) begin
            up = stab[2*p];
            dn = stab[2*p+1];
`ifdef PADDLE_AI_EN
            if (p == 1) begin
               c = m_y[1] + h / 2;
               up = (int'(ball_y) + 8) < c;
               dn = int'(ball_y) > (c + 8);
            end
`endif
            if (center)                     m_y[p] = (216 > lim) ? lim : 216;
            else if (m_y[p] > lim)          m_y[p] = lim;
            else if (en && tk && up && !dn) m_y[p] = (m_y[p] - PX < 16) ? 16 : m_y[p] - PX;
            else if (en && tk && dn && !up) m_y[p] = (m_y[p] + PX > lim) ? lim : m_y[p] + PX;
         end
         for (int i = 0; i < 4; i++) begin
            nmis = 0;
            for (int j = 1; j <= DEB; j++) if ((raw_hist[i][j] != 0) != stab[i]) nmis++;
            if (nmis == DEB) stab[i] = ~stab[i];
            for (int j = DEB; j > 0; j--) raw_hist[i][j] = raw_hist[i][j-1];
            raw_hist[i][0] = btn[i];
         end
      end
   end

   always @(negedge clk) begin
      if (model_on && rst === 1'b1) begin
         check_output("model_p1", int'(p1_y), m_y[0]);
         check_output("model_p2", int'(p2_y), m_y[1]);
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check_output("in_reset_p1", int'(p1_y), 216);
      rst = 1'b1;
      model_on = 1;
      apply_stimulus(4'b0000, 1'b1, 1'b0, 5);
      check_output("reset_p1", int'(p1_y), 216);
      check_output("reset_p2", int'(p2_y), 216);

      $display("[TB] saturation at top");
      apply_stimulus(4'b0001, 1'b1, 1'b0, 450);
      check_output("top_sat_p1", int'(p1_y), 16);
      apply_stimulus(4'b0001, 1'b1, 1'b0, 20);
      check_output("top_hold_p1", int'(p1_y), 16);

      $display("[TB] asynchronous reset");
      apply_stimulus(4'b0000, 1'b1, 1'b0, 1);
      #2 rst = 1'b0;
      #1;
      check_output("async_rst_p1", int'(p1_y), 216);
      check_output("async_rst_p2", int'(p2_y), 216);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      apply_stimulus(4'b0000, 1'b1, 1'b0, 20);
      check_output("idle_p1", int'(p1_y), 216);

      $display("[TB] bounce rejection");
      for (int k = 0; k < 5; k++) begin
         apply_stimulus(4'b0001, 1'b1, 1'b0, 3);
         apply_stimulus(4'b0000, 1'b1, 1'b0, 2);
      end
      apply_stimulus(4'b0000, 1'b1, 1'b0, 20);
      check_output("bounce_p1", int'(p1_y), 216);

`ifndef PADDLE_AI_EN
      $display("[TB] bottom saturation and bat growth");
      apply_stimulus(4'b1000, 1'b1, 1'b0, 450);
      check_output("bot_sat_p2", int'(p2_y), 416);
      apply_stimulus(4'b1000, 1'b1, 1'b1, 1);
      check_output("bat_grow_p2", int'(p2_y), 368);
      apply_stimulus(4'b1000, 1'b1, 1'b1, 30);
      check_output("bat_hold_p2", int'(p2_y), 368);
`endif

      $display("[TB] hold and freeze");
      apply_stimulus(4'b0000, 1'b1, 1'b1, 10);
      apply_stimulus(4'b0011, 1'b1, 1'b1, 40);
      check_output("both_btn_p1", int'(p1_y), 216);
      apply_stimulus(4'b0001, 1'b0, 1'b1, 40);
      check_output("freeze_p1", int'(p1_y), 216);
      apply_stimulus(4'b0010, 1'b1, 1'b1, 30);
      center = 1'b1;
      @(negedge clk);
      center = 1'b0;
      check_output("center_p1", int'(p1_y), 216);
      check_output("center_p2", int'(p2_y), 216);

`ifdef PADDLE_AI_EN
      $display("[TB] ball tracker");
      apply_stimulus(4'b0000, 1'b1, 1'b0, 10);
      ball_y = 11'd100;
      center = 1'b1;
      @(negedge clk);
      center = 1'b0;
      apply_stimulus(4'b0000, 1'b1, 1'b0, 300);
      check_output("ai_up_p2", int'(p2_y), 84);
      ball_y = 11'd300;
      apply_stimulus(4'b0000, 1'b1, 1'b0, 400);
      check_output("ai_dn_p2", int'(p2_y), 268);
`endif

      $display("[TB] random traffic");
      for (int r = 0; r < 400; r++) begin
         ball_y = 11'($urandom_range(0, 479));
         if ($urandom_range(0, 15) == 0) begin
            center = 1'b1;
            @(negedge clk);
            center = 1'b0;
         end
         apply_stimulus(4'($urandom), ($urandom_range(0, 7) != 0),
                        ($urandom_range(0, 5) == 0) ? ~bat_size : bat_size,
                        $urandom_range(1, 14));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
